// File: rtl/trace_tx.sv
// rtl/trace_tx.sv - TPIU-style DDR trace port transmitter (frames, syncs, idle filler)
// Optional feature: define TRACE_TX_HALFSYNC_EN to use halfsync (FF 7F) as idle filler;
// without it the filler is a full sync unit that also clears the frame counter.
module trace_tx #(
   parameter int SYNC_INTERVAL = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   width,
   input  logic         PkAvail,
   output logic         PkAck,
   input  logic [127:0] Packet,
   output logic [3:0]   traceDouta,
   output logic [3:0]   traceDoutb,
   output logic         idle
);

   typedef enum logic [1:0] {RSYNC, SYNC, FRAME, HALF} state_t;

   localparam logic [15:0] SYNC_INT = 16'(SYNC_INTERVAL);

   // Position registers describe the slice currently on the pins.
   state_t         state, state_nx;
   logic           run;
   logic [3:0]     byte_idx, byte_nx;
   logic [1:0]     slice_idx, slice_nx;
   logic [1:0]     wl, wl_nx;
   logic           fill, fill_nx;
   logic [127:0]   pkt, pkt_nx;
   logic [15:0]    fcnt, fcnt_nx, fcnt_end;

   logic           last_slice, boundary, frame_end, sync_due, ack_nx;
   logic [1:0]     slice_max;
   logic [3:0]     last_byte;
   logic [7:0]     byte_v;
   logic [2:0]     sh;
   logic [3:0]     a_nx, b_nx;

   // Sequencing: advance slice/byte, pick the next unit at each boundary.
   always_comb begin
      state_nx  = state;
      byte_nx   = byte_idx;
      slice_nx  = slice_idx;
      wl_nx     = wl;
      fill_nx   = fill;
      pkt_nx    = pkt;
      ack_nx    = 1'b0;

      case (wl)
         2'd3:    slice_max = 2'd0;
         2'd2:    slice_max = 2'd1;
         default: slice_max = 2'd3;
      endcase

      case (state)
         RSYNC:   last_byte = 4'd7;
         SYNC:    last_byte = 4'd3;
         HALF:    last_byte = 4'd1;
         default: last_byte = 4'd15;
      endcase

      last_slice = (slice_idx == slice_max);
      boundary   = run && last_slice && (byte_idx == last_byte);
      frame_end  = boundary && (state == FRAME);
      fcnt_end   = (frame_end && (fcnt != 16'hFFFF)) ? fcnt + 16'd1 : fcnt;
      sync_due   = (SYNC_INT != 16'd0) && (fcnt_end >= SYNC_INT);
      fcnt_nx    = fcnt_end;

      if (!run) begin
         // First cycle out of reset: the double sync starts immediately.
         state_nx = RSYNC;
         byte_nx  = 4'd0;
         slice_nx = 2'd0;
         wl_nx    = width;
         fill_nx  = 1'b0;
         fcnt_nx  = 16'd0;
      end else if (boundary) begin
         byte_nx  = 4'd0;
         slice_nx = 2'd0;
         wl_nx    = width;
         if (sync_due) begin
            state_nx = SYNC;
            fill_nx  = 1'b0;
            fcnt_nx  = 16'd0;
         end else if (PkAvail) begin
            state_nx = FRAME;
            pkt_nx   = Packet;
            ack_nx   = 1'b1;
            fill_nx  = 1'b0;
         end else begin
`ifdef TRACE_TX_HALFSYNC_EN
            state_nx = HALF;
            fill_nx  = 1'b1;
`else
            state_nx = SYNC;
            fill_nx  = 1'b1;
            fcnt_nx  = 16'd0;
`endif
         end
      end else if (last_slice) begin
         byte_nx  = byte_idx + 4'd1;
         slice_nx = 2'd0;
      end else begin
         slice_nx = slice_idx + 2'd1;
      end
   end

   // Pin data for the next position: select the byte, then its A/B slice.
   always_comb begin
      case (state_nx)
         FRAME:   byte_v = pkt_nx[{byte_nx, 3'b000} +: 8];
         HALF:    byte_v = byte_nx[0] ? 8'h7F : 8'hFF;
         default: byte_v = (byte_nx[1:0] == 2'd3) ? 8'h7F : 8'hFF;
      endcase
      sh = {slice_nx[0], 2'b00};
      case (wl_nx)
         2'd3: begin
            a_nx = byte_v[3:0];
            b_nx = byte_v[7:4];
         end
         2'd2: begin
            a_nx = {2'b00, byte_v[sh +: 2]};
            b_nx = {2'b00, byte_v[(sh + 3'd2) +: 2]};
         end
         default: begin
            a_nx = {3'b000, byte_v[{slice_nx, 1'b0}]};
            b_nx = {3'b000, byte_v[{slice_nx, 1'b1}]};
         end
      endcase
   end

   // Registered position and outputs; reset aborts any unit in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         run        <= 1'b0;
         state      <= RSYNC;
         byte_idx   <= 4'd0;
         slice_idx  <= 2'd0;
         wl         <= 2'd0;
         fill       <= 1'b0;
         pkt        <= '0;
         fcnt       <= 16'd0;
         traceDouta <= 4'd0;
         traceDoutb <= 4'd0;
         PkAck      <= 1'b0;
         idle       <= 1'b0;
      end else begin
         run        <= 1'b1;
         state      <= state_nx;
         byte_idx   <= byte_nx;
         slice_idx  <= slice_nx;
         wl         <= wl_nx;
         fill       <= fill_nx;
         pkt        <= pkt_nx;
         fcnt       <= fcnt_nx;
         traceDouta <= a_nx;
         traceDoutb <= b_nx;
         PkAck      <= ack_nx;
         idle       <= fill_nx;
      end
   end

endmodule

// File: tb/tb_trace_tx.sv
// tb/tb_trace_tx.sv - scoreboard bench for trace_tx
module tb_trace_tx;

   localparam int SI = 2;

   logic         clk_tb = 1'b0;
   logic         rst;
   logic [1:0]   width;
   logic         PkAvail;
   logic         PkAck;
   logic [127:0] Packet;
   logic [3:0]   traceDouta;
   logic [3:0]   traceDoutb;
   logic         idle;

   always #5 clk_tb = ~clk_tb;

   trace_tx #(.SYNC_INTERVAL(SI)) dut (
      .clk        (clk_tb),
      .rst        (rst),
      .width      (width),
      .PkAvail    (PkAvail),
      .PkAck      (PkAck),
      .Packet     (Packet),
      .traceDouta (traceDouta),
      .traceDoutb (traceDoutb),
      .idle       (idle)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ack;
      logic       idl;
      int         id;
   } exp_t;

   exp_t         q[$];
   int           errors = 0;
   int           checks = 0;
   int           seq_id = 0;
   logic [127:0] pk [4];
   int           npk = 0;
   int           restart_req = 0;

   function automatic void push(input logic [3:0] a, input logic [3:0] b,
                                input logic ack, input logic idl);
      exp_t e;
      e.a = a; e.b = b; e.ack = ack; e.idl = idl; e.id = seq_id;
      seq_id++;
      q.push_back(e);
   endfunction

   function automatic void push_byte(input logic [7:0] v, input logic [1:0] w,
                                     input logic ack, input logic idl);
      case (w)
         2'd3: push(v[3:0], v[7:4], ack, idl);
         2'd2: begin
            push({2'b00, v[1:0]}, {2'b00, v[3:2]}, ack, idl);
            push({2'b00, v[5:4]}, {2'b00, v[7:6]}, 1'b0, idl);
         end
         default: begin
            push({3'b000, v[0]}, {3'b000, v[1]}, ack, idl);
            push({3'b000, v[2]}, {3'b000, v[3]}, 1'b0, idl);
            push({3'b000, v[4]}, {3'b000, v[5]}, 1'b0, idl);
            push({3'b000, v[6]}, {3'b000, v[7]}, 1'b0, idl);
         end
      endcase
   endfunction

   function automatic void push_sync(input logic [1:0] w, input logic idl);
      push_byte(8'hFF, w, 1'b0, idl);
      push_byte(8'hFF, w, 1'b0, idl);
      push_byte(8'hFF, w, 1'b0, idl);
      push_byte(8'h7F, w, 1'b0, idl);
   endfunction

   function automatic void push_rsync(input logic [1:0] w);
      push_sync(w, 1'b0);
      push_sync(w, 1'b0);
   endfunction

   function automatic void push_filler(input logic [1:0] w);
`ifdef TRACE_TX_HALFSYNC_EN
      push_byte(8'hFF, w, 1'b0, 1'b1);
      push_byte(8'h7F, w, 1'b0, 1'b1);
`else
      push_sync(w, 1'b1);
`endif
   endfunction

   function automatic void push_frame(input logic [127:0] p, input logic [1:0] w);
      for (int j = 0; j < 16; j++)
         push_byte(p[8*j +: 8], w, (j == 0), 1'b0);
   endfunction

   // Packet producer: offers pk[] in order, advancing on each PkAck.
   initial begin
      int idx;
      int seen;
      idx = 0;
      seen = 0;
      PkAvail = 1'b0;
      Packet = '0;
      forever begin
         @(posedge clk_tb);
         #1;
         if (restart_req != seen) begin
            seen = restart_req;
            idx = 0;
         end else if (PkAck) begin
            idx++;
         end
         PkAvail = (idx < npk);
         Packet  = (idx < npk) ? pk[idx] : '0;
      end
   end

   // Monitor: one scoreboard entry per clock while entries are pending.
   initial begin
      forever begin
         @(negedge clk_tb);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (traceDouta !== e.a || traceDoutb !== e.b || PkAck !== e.ack || idle !== e.idl) begin
               errors++;
               $display("FAIL pins[%0d] got a=%h b=%h ack=%b idle=%b expected a=%h b=%h ack=%b idle=%b",
                        e.id, traceDouta, traceDoutb, PkAck, idle, e.a, e.b, e.ack, e.idl);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic start_test(input logic [1:0] w, input int n);
      npk = n;
      restart_req++;
      @(posedge clk_tb);
      #1;
      rst = 1'b1;
      width = w;
      @(posedge clk_tb);
      #1;
      push(4'h0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 3000) begin
         @(negedge clk_tb);
         n++;
      end
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain got %0d pending entries expected 0", q.size());
         q.delete();
      end
      #1;
   endtask

   initial begin
      rst = 1'b1;
      width = 2'd3;
      for (int i = 0; i < 4; i++) pk[i] = '0;

      // Idle link at width 3: double sync then filler.
      start_test(2'd3, 0);
      push_rsync(2'd3);
      push_filler(2'd3);
      push_filler(2'd3);
      push_filler(2'd3);
      wait_drain();

      // Frame 00..0F offered from reset.
      for (int j = 0; j < 16; j++) pk[0][8*j +: 8] = 8'(j);
      start_test(2'd3, 1);
      push_rsync(2'd3);
      push_frame(pk[0], 2'd3);
      push_filler(2'd3);
      wait_drain();

      // Width 2 frame whose first byte is 0x34.
      for (int j = 0; j < 16; j++) pk[0][8*j +: 8] = 8'(j * 37 + 11);
      pk[0][7:0] = 8'h34;
      start_test(2'd2, 1);
      push_rsync(2'd2);
      push_frame(pk[0], 2'd2);
      push_filler(2'd2);
      wait_drain();

      // Width 0 (one bit) frame.
      pk[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      start_test(2'd0, 1);
      push_rsync(2'd0);
      push_frame(pk[0], 2'd0);
      push_filler(2'd0);
      wait_drain();

      // Width 1 idle link.
      start_test(2'd1, 0);
      push_rsync(2'd1);
      push_filler(2'd1);
      wait_drain();

      // Periodic sync every two frames with back-to-back packets.
      pk[0] = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
      pk[1] = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_F001;
      pk[2] = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
      pk[3] = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
      start_test(2'd3, 4);
      push_rsync(2'd3);
      push_frame(pk[0], 2'd3);
      push_frame(pk[1], 2'd3);
      push_sync(2'd3, 1'b0);
      push_frame(pk[2], 2'd3);
      push_frame(pk[3], 2'd3);
      push_sync(2'd3, 1'b0);
      wait_drain();

      // Reset at byte 7 of a frame: abort, resync, frame not resent.
      for (int j = 0; j < 16; j++) pk[0][8*j +: 8] = 8'(j);
      start_test(2'd3, 1);
      push_rsync(2'd3);
      for (int j = 0; j < 8; j++) push_byte(8'(j), 2'd3, (j == 0), 1'b0);
      push(4'h0, 4'h0, 1'b0, 1'b0);
      push(4'h0, 4'h0, 1'b0, 1'b0);
      push_rsync(2'd3);
      push_filler(2'd3);
      repeat (16) @(posedge clk_tb);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk_tb);
      #1;
      rst = 1'b0;
      wait_drain();

      // Width change mid-unit only applies from the next unit.
      start_test(2'd3, 0);
      push_rsync(2'd3);
      push_filler(2'd3);
      push_filler(2'd2);
      repeat (9) @(posedge clk_tb);
      #1;
      width = 2'd2;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trace_tx.md
# trace_tx

TPIU-style trace port transmitter, the sending end of the link that the trace receiver (`traceIF`) decodes. It accepts 128-bit packets through a PkAvail/PkAck handshake and serializes them onto 1-, 2- or 4-bit DDR trace pins. It inserts full synchronisation sequences after reset and periodically between frames, and it fills idle time with halfsyncs. The block sits between the packet source and an external DDR output stage that drives `traceDouta` on the rising edge and `traceDoutb` on the falling edge of the forwarded `clk`.

## Interface
- `SYNC_INTERVAL`, 16: number of frames between full syncs; 0 disables periodic sync.
- `clk`  in  1  system clock; also forwarded as the trace clock.
- `rst`  in  1  reset, synchronous, active-high.
- `width`  in  2  bus width: 3 = 4 bit, 2 = 2 bit, 1 or 0 = 1 bit.
- `PkAvail`  in  1  packet source has a valid `Packet`.
- `PkAck`  out  1  one-cycle pulse: `Packet` was captured.
- `Packet`  in  128  frame data; byte `Packet[7:0]` is sent first.
- `traceDouta`  out  4  rising-edge data.
- `traceDoutb`  out  4  falling-edge data.
- `idle`  out  1  high while filler (halfsync) is being sent.

## Operation
- **Unit types:** FRAME (16 bytes of `Packet`), SYNC (bytes FF FF FF 7F), HALF (bytes FF 7F).
- **States:** RSYNC (two back-to-back SYNC units after reset), SYNC, FRAME, HALF.
- **Slices per clk, with n = 4/2/1 bits for width 3/2/≤1:**
  - A = next n LSBs of the current byte; B = the following n bits.
  - Width 3: A = byte[3:0], B = byte[7:4].
  - Width 2: byte[1:0]/byte[3:2], then byte[5:4]/byte[7:6].
  - Width ≤1: 4 cycles per byte, bit0/bit1 first.
  - Unused upper pins drive 0.
- **Unit boundary:** the cycle in which the last slice of a unit is output.
- **Decision at each boundary, in priority order:**
  1. `syncDue` → SYNC.
  2. `PkAvail` → FRAME.
  3. Otherwise → HALF.
- `syncDue` sets when the frame counter reaches `SYNC_INTERVAL`. The counter clears on any SYNC unit and increments at the end of each FRAME.
- `width` is latched at each unit start. A change mid-unit takes effect at the next unit.
- Units are never truncated: a HALF completes even if `PkAvail` rises mid-unit.

## Timing
- **Reset values:** `traceDouta` = 0, `traceDoutb` = 0, `PkAck` = 0, `idle` = 0, state = RSYNC, frame counter = 0.
- `rst` mid-unit aborts the unit immediately. The frame is dropped and no `PkAck` is issued for it unless already issued.
- First cycle after `rst` falls: first slice of FF (width 3: A = F, B = F).
- **Handshake:** at a boundary cycle with `PkAvail` = 1 and no sync due, `Packet` is captured at that edge. In the next cycle `PkAck` = 1 and the first slice of `Packet[7:0]` is on the pins. There is no bubble between units.
- The producer holds `Packet` stable while `PkAvail` = 1 and `PkAck` = 0. It may present the next packet the cycle after `PkAck`.
- All outputs are registered.
- **Throughput:** one byte per 1/2/4 clks for width 3/2/≤1.

## Configuration
- `TRACE_TX_HALFSYNC_EN`
  - **Defined:** idle filler is HALF units and `idle` is high during them.
  - **Undefined:** idle filler is full SYNC units, which also clear the frame counter; `idle` is high during filler SYNCs and low during due/reset SYNCs.

## Test plan
- Width 3, `PkAvail` = 0 after reset → A/B pairs F/F ×3, F/7, F/F ×3, F/7 (two syncs), then F/F, F/7 repeating with `idle` = 1.
- Width 3, `Packet` bytes 00..0F (`Packet[7:0]` = 00) offered at reset → after the two syncs, `PkAck` pulse, then pairs 0/0, 1/0, 2/0 … F/0; next unit HALF.
- Width 2, single byte 0x34 inside a frame → cycle 1: A = 0, B = 1; cycle 2: A = 3, B = 0; pins [3:2] = 0.
- `SYNC_INTERVAL` = 2, `PkAvail` held high with a new packet after every ack → pattern FRAME, FRAME, SYNC, FRAME, FRAME, SYNC; `PkAck` exactly once per frame.
- `rst` asserted at byte 7 of a frame → outputs 0 during reset; restart with the RSYNC sequence; the frame is not resent.
- Loopback: width 3/2/1 output fed to `traceIF` with matching width → `sync` asserted, and each `Packet` received equals the `Packet` sent.
